// File: rtl/keylock_ctrl.sv
// keylock_ctrl: keypad lock sequencer. Collects 6-digit BCD entries, compares
// them against a programmable code, counts consecutive failures, enforces a
// timed lockout, and lets the code be reprogrammed while unlocked.
module keylock_ctrl #(
    parameter logic [23:0] DEFAULT_CODE   = 24'h335256,
    parameter int          MAX_FAIL       = 3,
    parameter int          LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       relock,
    input  logic       prog_start,
    output logic       locked,
    output logic       lockout_active,
    output logic       fail_pulse,
    output logic [3:0] fail_count,
    output logic [2:0] entry_count
);

    typedef enum logic [2:0] {
        ST_ENTRY    = 3'd0,
        ST_CHECK    = 3'd1,
        ST_LOCKOUT  = 3'd2,
        ST_UNLOCKED = 3'd3,
        ST_PROGRAM  = 3'd4
    } state_t;

    localparam logic [3:0]  MAX_FAIL_L = 4'(MAX_FAIL);
    localparam logic [15:0] LOCK_INIT  = 16'(LOCKOUT_CYCLES - 1);

    state_t      state_reg;
    logic [23:0] code_reg;
    logic [23:0] entry_buf_reg;
    logic [2:0]  entry_count_reg;
    logic [3:0]  fail_count_reg;
    logic [15:0] timer_reg;
    logic        fail_pulse_reg;

    // Key classification and the buffer with the incoming digit appended
    logic        digit_key;
    logic        clear_key;
    logic [23:0] shifted_buf;

    assign digit_key   = key_valid && (key <= 4'd9);
    assign clear_key   = key_valid && (key == 4'hF);
    assign shifted_buf = {entry_buf_reg[19:0], key};

    // Status outputs decoded directly from the state register
    assign locked         = !((state_reg == ST_UNLOCKED) || (state_reg == ST_PROGRAM));
    assign lockout_active = (state_reg == ST_LOCKOUT);
    assign fail_pulse     = fail_pulse_reg;
    assign fail_count     = fail_count_reg;
    assign entry_count    = entry_count_reg;

    // Main sequencer: state, code register, entry buffer, failure and lockout tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= ST_ENTRY;
            code_reg        <= DEFAULT_CODE;
            entry_buf_reg   <= 24'd0;
            entry_count_reg <= 3'd0;
            fail_count_reg  <= 4'd0;
            timer_reg       <= 16'd0;
            fail_pulse_reg  <= 1'b0;
        end else begin
            fail_pulse_reg <= 1'b0;
            case (state_reg)
                ST_ENTRY: begin
                    if (clear_key) begin
                        entry_buf_reg   <= 24'd0;
                        entry_count_reg <= 3'd0;
                    end else if (digit_key) begin
                        entry_buf_reg <= shifted_buf;
                        if (entry_count_reg == 3'd5) begin
                            entry_count_reg <= 3'd6;
                            state_reg       <= ST_CHECK;
                        end else begin
                            entry_count_reg <= entry_count_reg + 3'd1;
                        end
                    end
                end

                ST_CHECK: begin
                    entry_buf_reg   <= 24'd0;
                    entry_count_reg <= 3'd0;
                    if (entry_buf_reg == code_reg) begin
                        state_reg      <= ST_UNLOCKED;
                        fail_count_reg <= 4'd0;
                    end else begin
                        fail_pulse_reg <= 1'b1;
                        // Reaching the limit saturates the count and starts the lockout
                        if (fail_count_reg >= MAX_FAIL_L - 4'd1) begin
                            fail_count_reg <= MAX_FAIL_L;
                            timer_reg      <= LOCK_INIT;
                            state_reg      <= ST_LOCKOUT;
                        end else begin
                            fail_count_reg <= fail_count_reg + 4'd1;
                            state_reg      <= ST_ENTRY;
                        end
                    end
                end

                ST_LOCKOUT: begin
                    if (timer_reg == 16'd0) begin
                        state_reg      <= ST_ENTRY;
                        fail_count_reg <= 4'd0;
                    end else begin
                        timer_reg <= timer_reg - 16'd1;
                    end
                end

                ST_UNLOCKED: begin
                    if (relock) begin
                        state_reg <= ST_ENTRY;
                    end else if (prog_start) begin
                        state_reg       <= ST_PROGRAM;
                        entry_buf_reg   <= 24'd0;
                        entry_count_reg <= 3'd0;
                    end
                end

                ST_PROGRAM: begin
                    if (relock) begin
                        state_reg       <= ST_ENTRY;
                        entry_buf_reg   <= 24'd0;
                        entry_count_reg <= 3'd0;
                    end else if (clear_key) begin
                        state_reg       <= ST_UNLOCKED;
                        entry_buf_reg   <= 24'd0;
                        entry_count_reg <= 3'd0;
                    end else if (digit_key) begin
                        if (entry_count_reg == 3'd5) begin
                            code_reg        <= shifted_buf;
                            entry_buf_reg   <= 24'd0;
                            entry_count_reg <= 3'd0;
                            state_reg       <= ST_UNLOCKED;
                        end else begin
                            entry_buf_reg   <= shifted_buf;
                            entry_count_reg <= entry_count_reg + 3'd1;
                        end
                    end
                end

                default: begin
                    state_reg       <= ST_ENTRY;
                    entry_buf_reg   <= 24'd0;
                    entry_count_reg <= 3'd0;
                    timer_reg       <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keylock_ctrl.sv
// tb_keylock_ctrl: vector table, directed corner-case sequences and a random
// run checked against a flag/queue reference model of the keypad lock.
module tb_keylock_ctrl;

    localparam logic [23:0] DEF_CODE = 24'h335256;
    localparam int          MAXF     = 3;
    localparam int          LOCKC    = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key = 4'd0;
    logic       key_valid = 1'b0;
    logic       relock = 1'b0;
    logic       prog_start = 1'b0;
    logic       locked;
    logic       lockout_active;
    logic       fail_pulse;
    logic [3:0] fail_count;
    logic [2:0] entry_count;

    int tests = 0;
    int fails = 0;
    int fp_seen = 0;

    always #5 clk = ~clk;

    keylock_ctrl #(
        .DEFAULT_CODE  (DEF_CODE),
        .MAX_FAIL      (MAXF),
        .LOCKOUT_CYCLES(LOCKC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key           (key),
        .key_valid     (key_valid),
        .relock        (relock),
        .prog_start    (prog_start),
        .locked        (locked),
        .lockout_active(lockout_active),
        .fail_pulse    (fail_pulse),
        .fail_count    (fail_count),
        .entry_count   (entry_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_unlocked = 0;
    bit          m_prog     = 0;
    bit          m_fp       = 0;
    int          m_lock_left = 0;
    int          m_fails    = 0;
    int          m_q[$];
    logic [23:0] m_code = DEF_CODE;

    function automatic logic [23:0] q_val();
        logic [23:0] v = 24'd0;
        foreach (m_q[i]) v = (v << 4) | 24'(m_q[i]);
        return v;
    endfunction

    function automatic logic [3:0] code_digit(input logic [23:0] c, input int n);
        logic [23:0] s;
        s = c >> (20 - 4 * n);
        return s[3:0];
    endfunction

    task automatic model_step(input logic r, input logic kv, input logic [3:0] k,
                              input logic rl, input logic ps);
        if (!r) begin
            m_unlocked = 0; m_prog = 0; m_fp = 0; m_lock_left = 0;
            m_fails = 0; m_q.delete(); m_code = DEF_CODE;
            return;
        end
        m_fp = 0;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (!m_unlocked && !m_prog && m_q.size() == 6) begin
            if (q_val() == m_code) begin
                m_unlocked = 1;
                m_fails = 0;
            end else begin
                m_fp = 1;
                m_fails = (m_fails + 1 > MAXF) ? MAXF : m_fails + 1;
                if (m_fails == MAXF) m_lock_left = LOCKC;
            end
            m_q.delete();
        end else if (m_prog) begin
            if (rl) begin
                m_prog = 0; m_q.delete();
            end else if (kv && k == 4'hF) begin
                m_prog = 0; m_unlocked = 1; m_q.delete();
            end else if (kv && k <= 4'd9) begin
                m_q.push_back(int'(k));
                if (m_q.size() == 6) begin
                    m_code = q_val();
                    m_q.delete();
                    m_prog = 0;
                    m_unlocked = 1;
                end
            end
        end else if (m_unlocked) begin
            if (rl) m_unlocked = 0;
            else if (ps) begin
                m_unlocked = 0; m_prog = 1; m_q.delete();
            end
        end else if (kv) begin
            if (k == 4'hF) m_q.delete();
            else if (k <= 4'd9) m_q.push_back(int'(k));
        end
    endtask

    // Apply one cycle of inputs, step the model, compare every output
    task automatic drive(input logic r, input logic kv, input logic [3:0] k,
                         input logic rl, input logic ps);
        reset = r; key_valid = kv; key = k; relock = rl; prog_start = ps;
        @(posedge clk);
        #1;
        model_step(r, kv, k, rl, ps);
        if (fail_pulse) fp_seen++;
        chk("locked", int'(locked), int'(!(m_unlocked || m_prog)));
        chk("lockout_active", int'(lockout_active), int'(m_lock_left > 0));
        chk("fail_pulse", int'(fail_pulse), int'(m_fp));
        chk("fail_count", int'(fail_count), m_fails);
        chk("entry_count", int'(entry_count), m_q.size());
        key_valid = 1'b0; relock = 1'b0; prog_start = 1'b0;
    endtask

    task automatic idle();
        drive(1, 0, 4'd0, 0, 0);
    endtask

    task automatic enter(input logic [23:0] c);
        for (int i = 0; i < 6; i++) drive(1, 1, code_digit(c, i), 0, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 4'd0, 0, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       r;
        logic       kv;
        logic [3:0] k;
        logic       rl;
        logic       ps;
        logic       e_locked;
        logic       e_lo;
        logic       e_fp;
        logic [3:0] e_fc;
        logic [2:0] e_ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic kv, input logic [3:0] k,
                                input logic rl, input logic ps, input logic el,
                                input logic elo, input logic efp, input logic [3:0] efc,
                                input logic [2:0] eec);
        vec_t v;
        v.r = r; v.kv = kv; v.k = k; v.rl = rl; v.ps = ps;
        v.e_locked = el; v.e_lo = elo; v.e_fp = efp; v.e_fc = efc; v.e_ec = eec;
        return v;
    endfunction

    task automatic push_code(input logic [23:0] c, input logic [3:0] fc);
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1, 1, code_digit(c, i), 0, 0, 1, 0, 0, fc, 3'(i + 1)));
    endtask

    initial begin
        int n;
        int fp_before;

        // Reset, correct code, relock
        tbl.push_back(mk(0, 0, 4'd0, 0, 0, 1, 0, 0, 0, 0));
        push_code(DEF_CODE, 0);
        tbl.push_back(mk(1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'd0, 1, 0, 1, 0, 0, 0, 0));
        // 3,3,C(ignored),5,F(clear) then the full code
        tbl.push_back(mk(1, 1, 4'd3, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 4'd3, 0, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(1, 1, 4'hC, 0, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(1, 1, 4'd5, 0, 0, 1, 0, 0, 0, 3));
        tbl.push_back(mk(1, 1, 4'hF, 0, 0, 1, 0, 0, 0, 0));
        push_code(DEF_CODE, 0);
        tbl.push_back(mk(1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'd0, 1, 0, 1, 0, 0, 0, 0));
        // One wrong attempt
        push_code(24'h123456, 0);
        tbl.push_back(mk(1, 0, 4'd0, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 4'd0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 4'hB, 0, 0, 1, 0, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].r; key_valid = tbl[i].kv; key = tbl[i].k;
            relock = tbl[i].rl; prog_start = tbl[i].ps;
            @(posedge clk);
            #1;
            chk("vec_locked", int'(locked), int'(tbl[i].e_locked));
            chk("vec_lockout", int'(lockout_active), int'(tbl[i].e_lo));
            chk("vec_fail_pulse", int'(fail_pulse), int'(tbl[i].e_fp));
            chk("vec_fail_count", int'(fail_count), int'(tbl[i].e_fc));
            chk("vec_entry_count", int'(entry_count), int'(tbl[i].e_ec));
            $display("[TB] vec %0d key=%h kv=%b -> locked=%b ec=%0d fc=%0d fp=%b",
                     i, tbl[i].k, tbl[i].kv, locked, entry_count, fail_count, fail_pulse);
        end

        // Three failures then a timed lockout with keys ignored
        do_reset();
        fp_before = fp_seen;
        for (int a = 0; a < 2; a++) begin
            enter(24'h123456);
            idle();
        end
        enter(24'h123456);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1, 1, 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (lockout_active) n++;
            else if (n > 0) break;
        end
        chk("fail_pulses_to_lockout", fp_seen - fp_before, 3);
        chk("lockout_cycles", n, LOCKC);
        chk("fail_count_after_lockout", int'(fail_count), 0);
        enter(DEF_CODE);
        idle();
        chk("unlock_after_lockout", int'(locked), 0);
        $display("[TB] lockout sequence: %0d lockout cycles", n);

        // Program 987654, relock; old code now fails, new code unlocks
        drive(1, 0, 4'd0, 0, 1);
        enter(24'h987654);
        chk("program_done_unlocked", int'(locked), 0);
        drive(1, 0, 4'd0, 1, 0);
        enter(DEF_CODE);
        idle();
        chk("old_code_rejected", int'(fail_pulse), 1);
        enter(24'h987654);
        idle();
        chk("new_code_unlocks", int'(locked), 0);
        $display("[TB] program sequence: new code accepted");

        // relock and prog_start together: relock wins
        drive(1, 0, 4'd0, 1, 1);
        chk("relock_priority_locked", int'(locked), 1);
        enter(24'h987654);
        idle();
        chk("code_kept_after_relock", int'(locked), 0);
        $display("[TB] relock priority sequence done");

        // Reset mid-programming discards the programmed code
        drive(1, 0, 4'd0, 0, 1);
        drive(1, 1, 4'd1, 0, 0);
        drive(1, 1, 4'd1, 0, 0);
        drive(1, 1, 4'd1, 0, 0);
        do_reset();
        chk("rst_prog_locked", int'(locked), 1);
        chk("rst_prog_entry_count", int'(entry_count), 0);
        enter(24'h987654);
        idle();
        chk("rst_restores_default_reject", int'(fail_pulse), 1);
        enter(DEF_CODE);
        idle();
        chk("rst_restores_default_accept", int'(locked), 0);
        $display("[TB] reset mid-program sequence done");

        // Reset mid-lockout
        do_reset();
        for (int a = 0; a < 3; a++) begin
            enter(24'h000000);
            idle();
        end
        chk("in_lockout", int'(lockout_active), 1);
        idle();
        do_reset();
        chk("rst_lockout_inactive", int'(lockout_active), 0);
        chk("rst_lockout_fail_count", int'(fail_count), 0);
        $display("[TB] reset mid-lockout sequence done");

        // Random run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] k;
            logic r;
            r = ($urandom_range(0, 199) != 0);
            if (m_q.size() < 6 && !m_prog && $urandom_range(0, 9) < 7)
                k = code_digit(m_code, m_q.size());
            else
                k = 4'($urandom_range(0, 15));
            drive(r, 1'($urandom_range(0, 1)), k, ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 7) == 0));
        end
        $display("[TB] random run done, code model=%h", m_code);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
